// File: rtl/cc_fifo_ctrl_if.sv
// Producer/consumer bundle for cc_fifo_ctrl: control, write side, read side, status and error flags.
// master = the logic driving the FIFO; slave = the FIFO itself.
interface cc_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 5
);
  logic                  flush_i;
  logic [CNT_W-1:0]      afull_thr_i;
  logic [CNT_W-1:0]      aempty_thr_i;
  logic                  wren_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  full_o;
  logic                  afull_o;
  logic                  rden_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rvalid_o;
  logic                  empty_o;
  logic                  aempty_o;
  logic [CNT_W-1:0]      count_o;
  logic                  err_clr_i;
  logic                  ovf_o;
  logic                  udf_o;

  modport master (
    output flush_i, afull_thr_i, aempty_thr_i, wren_i, wdata_i, rden_i, err_clr_i,
    input  full_o, afull_o, rdata_o, rvalid_o, empty_o, aempty_o, count_o, ovf_o, udf_o
  );

  modport slave (
    input  flush_i, afull_thr_i, aempty_thr_i, wren_i, wdata_i, rden_i, err_clr_i,
    output full_o, afull_o, rdata_o, rvalid_o, empty_o, aempty_o, count_o, ovf_o, udf_o
  );
endinterface

// File: rtl/cc_fifo_ctrl.sv
// Synchronous FIFO with programmable almost-full/empty, occupancy count, flush and sticky
// overflow/underflow flags; read data is fall-through (OUTPUT_REG=0) or registered (OUTPUT_REG=1).
module cc_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_REG = 0
) (
  input logic           clk,
  input logic           rst,
  cc_fifo_ctrl_if.slave fifo_if
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = CNT_W - 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0] wrptr_q, wrptr_d;
  logic [CNT_W-1:0] rdptr_q, rdptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic wr_acc;
  logic rd_acc;
  logic wr_commit;
  logic rd_commit;

  // Acceptance looks only at registered flags so there is no input-to-flag combinational path.
  assign wr_acc    = fifo_if.wren_i & ~full_q;
  assign rd_acc    = fifo_if.rden_i & ~empty_q;
  assign wr_commit = wr_acc & ~fifo_if.flush_i;
  assign rd_commit = rd_acc & ~fifo_if.flush_i;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (fifo_if.flush_i) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      full_d  = 1'b0;
      empty_d = 1'b1;
    end else begin
      wrptr_d = wrptr_q + CNT_W'(wr_acc);
      rdptr_d = rdptr_q + CNT_W'(rd_acc);
      count_d = wrptr_d - rdptr_d;
      empty_d = (wrptr_d == rdptr_d);
      full_d  = (wrptr_d[AW] != rdptr_d[AW]) && (wrptr_d[AW-1:0] == rdptr_d[AW-1:0]);
    end
  end

  // A flushed cycle discards its request, so it can never raise an error; a new error beats err_clr_i.
  always_comb begin
    ovf_d = (ovf_q & ~fifo_if.err_clr_i) | (fifo_if.wren_i & full_q  & ~fifo_if.flush_i);
    udf_d = (udf_q & ~fifo_if.err_clr_i) | (fifo_if.rden_i & empty_q & ~fifo_if.flush_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_commit) begin
      mem_q[wrptr_q[AW-1:0]] <= fifo_if.wdata_i;
    end
  end

  assign fifo_if.full_o   = full_q;
  assign fifo_if.empty_o  = empty_q;
  assign fifo_if.count_o  = count_q;
  assign fifo_if.ovf_o    = ovf_q;
  assign fifo_if.udf_o    = udf_q;
  assign fifo_if.afull_o  = (count_q >= fifo_if.afull_thr_i);
  assign fifo_if.aempty_o = (count_q <= fifo_if.aempty_thr_i);

  if (OUTPUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_commit;
      if (rd_commit) begin
        rdata_d = mem_q[rdptr_q[AW-1:0]];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign fifo_if.rdata_o  = rdata_q;
    assign fifo_if.rvalid_o = rvalid_q;
  end else begin : g_fwft
    assign fifo_if.rdata_o  = mem_q[rdptr_q[AW-1:0]];
    assign fifo_if.rvalid_o = ~empty_q;
  end
endmodule

// File: tb/tb_cc_fifo_ctrl.sv
// Bench for cc_fifo_ctrl: one fall-through and one registered-output instance, scoreboard per instance.
module tb_cc_fifo_ctrl;
  localparam int DW = 32;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_fifo_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus0 ();
  cc_fifo_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus1 ();

  cc_fifo_ctrl #(.FIFO_DEPTH(16), .DATA_WIDTH(DW), .OUTPUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_if(bus0)
  );
  cc_fifo_ctrl #(.FIFO_DEPTH(16), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_if(bus1)
  );

  int nchk  = 0;
  int npass = 0;
  logic [DW-1:0] sb0 [$];
  logic [DW-1:0] sb1 [$];
  logic [DW-1:0] exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nchk++; if (bus0.count_o !== 5'd0) $display("FAIL rst_count0 act=%0d exp=0", bus0.count_o); else npass++;
    nchk++; if (bus0.empty_o !== 1'b1) $display("FAIL rst_empty0 act=%b exp=1", bus0.empty_o); else npass++;
    nchk++; if (bus0.full_o !== 1'b0) $display("FAIL rst_full0 act=%b exp=0", bus0.full_o); else npass++;
    nchk++; if ({bus0.ovf_o, bus0.udf_o} !== 2'b00) $display("FAIL rst_err0 act=%b exp=00", {bus0.ovf_o, bus0.udf_o}); else npass++;
    nchk++; if (bus0.rvalid_o !== 1'b0) $display("FAIL rst_rvalid0 act=%b exp=0", bus0.rvalid_o); else npass++;
    nchk++; if (bus1.rvalid_o !== 1'b0) $display("FAIL rst_rvalid1 act=%b exp=0", bus1.rvalid_o); else npass++;
    nchk++; if (bus1.rdata_o !== 32'h0) $display("FAIL rst_rdata1 act=%h exp=0", bus1.rdata_o); else npass++;
    nchk++; if ({bus1.empty_o, bus1.count_o} !== 6'b1_00000) $display("FAIL rst_state1 act=%b exp=100000", {bus1.empty_o, bus1.count_o}); else npass++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      bus0.wren_i  = 1'b1;
      bus0.wdata_i = 32'h11 * (i + 1);
      if (i == 0) begin
        nchk++; if (bus0.empty_o !== 1'b1) $display("FAIL basic_empty_pre act=%b exp=1", bus0.empty_o); else npass++;
      end
      tick();
      sb0.push_back(32'h11 * (i + 1));
      nchk++; if (bus0.count_o !== CW'(sb0.size())) $display("FAIL basic_count act=%0d exp=%0d", bus0.count_o, sb0.size()); else npass++;
      if (i == 0) begin
        nchk++; if (bus0.empty_o !== 1'b0) $display("FAIL basic_empty_post act=%b exp=0", bus0.empty_o); else npass++;
        nchk++; if (bus0.rdata_o !== 32'h11) $display("FAIL basic_head act=%h exp=11", bus0.rdata_o); else npass++;
      end
    end
    bus0.wren_i = 1'b0;
    bus0.rden_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d = sb0.pop_front();
      nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL basic_rdata act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
      tick();
    end
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.empty_o !== 1'b1) $display("FAIL basic_empty_end act=%b exp=1", bus0.empty_o); else npass++;
    nchk++; if (bus0.count_o !== 5'd0) $display("FAIL basic_count_end act=%0d exp=0", bus0.count_o); else npass++;
  endtask

  task automatic fill0(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus0.wren_i  = 1'b1;
      bus0.wdata_i = base + DW'(i);
      tick();
      sb0.push_back(base + DW'(i));
    end
    bus0.wren_i = 1'b0;
  endtask

  task automatic test_full();
    fill0(32'hA000_0000, 16);
    nchk++; if (bus0.full_o !== 1'b1) $display("FAIL full_flag act=%b exp=1", bus0.full_o); else npass++;
    nchk++; if (bus0.count_o !== 5'd16) $display("FAIL full_count act=%0d exp=16", bus0.count_o); else npass++;
    nchk++; if (bus0.afull_o !== 1'b1) $display("FAIL full_afull act=%b exp=1", bus0.afull_o); else npass++;
    bus0.wren_i  = 1'b1;
    bus0.wdata_i = 32'hDEAD_DEAD;
    tick();
    bus0.wren_i = 1'b0;
    nchk++; if (bus0.ovf_o !== 1'b1) $display("FAIL full_ovf act=%b exp=1", bus0.ovf_o); else npass++;
    nchk++; if (bus0.count_o !== 5'd16) $display("FAIL full_count_ovf act=%0d exp=16", bus0.count_o); else npass++;
    bus0.rden_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = sb0.pop_front();
      nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL full_rdata act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
      tick();
    end
    bus0.rden_i = 1'b0;
    nchk++; if ({bus0.empty_o, bus0.count_o} !== 6'b1_00000) $display("FAIL full_drained act=%b exp=100000", {bus0.empty_o, bus0.count_o}); else npass++;
    nchk++; if (bus0.udf_o !== 1'b0) $display("FAIL full_udf act=%b exp=0", bus0.udf_o); else npass++;
  endtask

  task automatic test_full_rw();
    bus0.err_clr_i = 1'b1;
    tick();
    bus0.err_clr_i = 1'b0;
    nchk++; if (bus0.ovf_o !== 1'b0) $display("FAIL frw_clr0 act=%b exp=0", bus0.ovf_o); else npass++;
    fill0(32'hB000_0000, 16);
    bus0.wren_i  = 1'b1;
    bus0.wdata_i = 32'hBEEF_BEEF;
    bus0.rden_i  = 1'b1;
    exp_d = sb0.pop_front();
    nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL frw_rdata act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
    tick();
    bus0.wren_i = 1'b0;
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.count_o !== 5'd15) $display("FAIL frw_count act=%0d exp=15", bus0.count_o); else npass++;
    nchk++; if (bus0.ovf_o !== 1'b1) $display("FAIL frw_ovf act=%b exp=1", bus0.ovf_o); else npass++;
    nchk++; if (bus0.full_o !== 1'b0) $display("FAIL frw_full act=%b exp=0", bus0.full_o); else npass++;
    bus0.err_clr_i = 1'b1;
    tick();
    bus0.err_clr_i = 1'b0;
    nchk++; if (bus0.ovf_o !== 1'b0) $display("FAIL frw_clr act=%b exp=0", bus0.ovf_o); else npass++;
    bus0.rden_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_d = sb0.pop_front();
      nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL frw_drain act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
      tick();
    end
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.empty_o !== 1'b1) $display("FAIL frw_empty act=%b exp=1", bus0.empty_o); else npass++;
  endtask

  task automatic test_thresholds();
    fill0(32'hC000_0000, 5);
    bus0.afull_thr_i  = 5'd5;
    bus0.aempty_thr_i = 5'd4;
    #1;
    nchk++; if ({bus0.afull_o, bus0.aempty_o} !== 2'b10) $display("FAIL thr_5_4 act=%b exp=10", {bus0.afull_o, bus0.aempty_o}); else npass++;
    bus0.afull_thr_i = 5'd6;
    #1;
    nchk++; if (bus0.afull_o !== 1'b0) $display("FAIL thr_af6 act=%b exp=0", bus0.afull_o); else npass++;
    bus0.aempty_thr_i = 5'd5;
    #1;
    nchk++; if (bus0.aempty_o !== 1'b1) $display("FAIL thr_ae5 act=%b exp=1", bus0.aempty_o); else npass++;
    bus0.afull_thr_i = 5'd31;
    #1;
    nchk++; if (bus0.afull_o !== 1'b0) $display("FAIL thr_af31 act=%b exp=0", bus0.afull_o); else npass++;
    bus0.afull_thr_i  = 5'd0;
    bus0.aempty_thr_i = 5'd0;
    #1;
    nchk++; if ({bus0.afull_o, bus0.aempty_o} !== 2'b10) $display("FAIL thr_0_0 act=%b exp=10", {bus0.afull_o, bus0.aempty_o}); else npass++;
    bus0.rden_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_d = sb0.pop_front();
      nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL thr_rdata act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
      tick();
    end
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.aempty_o !== 1'b1) $display("FAIL thr_ae_empty act=%b exp=1", bus0.aempty_o); else npass++;
    bus0.afull_thr_i  = 5'd12;
    bus0.aempty_thr_i = 5'd2;
  endtask

  task automatic test_outreg();
    bus1.wren_i  = 1'b1;
    bus1.wdata_i = 32'hA5;
    tick();
    sb1.push_back(32'hA5);
    bus1.wren_i = 1'b0;
    nchk++; if ({bus1.rvalid_o, bus1.count_o} !== 6'b0_00001) $display("FAIL oreg_wr act=%b exp=000001", {bus1.rvalid_o, bus1.count_o}); else npass++;
    bus1.rden_i = 1'b1;
    tick();
    bus1.rden_i = 1'b0;
    nchk++; if (bus1.rvalid_o !== 1'b1) $display("FAIL oreg_rvalid act=%b exp=1", bus1.rvalid_o); else npass++;
    if (bus1.rvalid_o === 1'b1) begin
      exp_d = sb1.pop_front();
      nchk++; if (bus1.rdata_o !== exp_d) $display("FAIL oreg_rdata act=%h exp=%h", bus1.rdata_o, exp_d); else npass++;
    end
    tick();
    nchk++; if (bus1.rvalid_o !== 1'b0) $display("FAIL oreg_pulse act=%b exp=0", bus1.rvalid_o); else npass++;
    nchk++; if (bus1.rdata_o !== 32'hA5) $display("FAIL oreg_hold act=%h exp=a5", bus1.rdata_o); else npass++;
    bus1.rden_i = 1'b1;
    tick();
    bus1.rden_i = 1'b0;
    nchk++; if ({bus1.udf_o, bus1.rvalid_o} !== 2'b10) $display("FAIL oreg_udf act=%b exp=10", {bus1.udf_o, bus1.rvalid_o}); else npass++;
    bus1.rden_i    = 1'b1;
    bus1.err_clr_i = 1'b1;
    tick();
    bus1.rden_i = 1'b0;
    nchk++; if (bus1.udf_o !== 1'b1) $display("FAIL oreg_setwins act=%b exp=1", bus1.udf_o); else npass++;
    tick();
    bus1.err_clr_i = 1'b0;
    nchk++; if (bus1.udf_o !== 1'b0) $display("FAIL oreg_clr act=%b exp=0", bus1.udf_o); else npass++;
    bus1.wren_i  = 1'b1;
    bus1.wdata_i = 32'h77;
    tick();
    bus1.wren_i  = 1'b0;
    bus1.flush_i = 1'b1;
    bus1.rden_i  = 1'b1;
    tick();
    bus1.flush_i = 1'b0;
    bus1.rden_i  = 1'b0;
    nchk++; if ({bus1.rvalid_o, bus1.empty_o, bus1.count_o} !== 7'b01_00000) $display("FAIL oreg_flush act=%b exp=0100000", {bus1.rvalid_o, bus1.empty_o, bus1.count_o}); else npass++;
    nchk++; if (bus1.rdata_o !== 32'hA5) $display("FAIL oreg_flush_hold act=%h exp=a5", bus1.rdata_o); else npass++;
  endtask

  task automatic test_flush();
    bus0.rden_i = 1'b1;
    tick();
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.udf_o !== 1'b1) $display("FAIL fl_udf_pre act=%b exp=1", bus0.udf_o); else npass++;
    fill0(32'hD000_0000, 8);
    nchk++; if (bus0.count_o !== 5'd8) $display("FAIL fl_count8 act=%0d exp=8", bus0.count_o); else npass++;
    bus0.flush_i = 1'b1;
    bus0.wren_i  = 1'b1;
    bus0.wdata_i = 32'hFF;
    tick();
    bus0.flush_i = 1'b0;
    bus0.wren_i  = 1'b0;
    sb0.delete();
    nchk++; if ({bus0.empty_o, bus0.full_o, bus0.count_o} !== 7'b10_00000) $display("FAIL fl_state act=%b exp=1000000", {bus0.empty_o, bus0.full_o, bus0.count_o}); else npass++;
    nchk++; if ({bus0.ovf_o, bus0.udf_o} !== 2'b01) $display("FAIL fl_errs act=%b exp=01", {bus0.ovf_o, bus0.udf_o}); else npass++;
    fill0(32'hE000_0000, 1);
    for (int i = 1; i <= 40; i++) begin
      bus0.wren_i  = 1'b1;
      bus0.rden_i  = 1'b1;
      bus0.wdata_i = 32'hE000_0000 + DW'(i);
      exp_d = sb0.pop_front();
      nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL wrap_rdata act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
      tick();
      sb0.push_back(32'hE000_0000 + DW'(i));
      nchk++; if (bus0.count_o !== CW'(sb0.size())) $display("FAIL wrap_count act=%0d exp=%0d", bus0.count_o, sb0.size()); else npass++;
    end
    bus0.wren_i = 1'b0;
    exp_d = sb0.pop_front();
    nchk++; if (bus0.rdata_o !== exp_d) $display("FAIL wrap_last act=%h exp=%h", bus0.rdata_o, exp_d); else npass++;
    tick();
    bus0.rden_i = 1'b0;
    nchk++; if (bus0.empty_o !== 1'b1) $display("FAIL wrap_empty act=%b exp=1", bus0.empty_o); else npass++;
  endtask

  initial begin
    bus0.flush_i = 1'b0; bus0.wren_i = 1'b0; bus0.rden_i = 1'b0; bus0.err_clr_i = 1'b0;
    bus0.wdata_i = '0; bus0.afull_thr_i = 5'd12; bus0.aempty_thr_i = 5'd2;
    bus1.flush_i = 1'b0; bus1.wren_i = 1'b0; bus1.rden_i = 1'b0; bus1.err_clr_i = 1'b0;
    bus1.wdata_i = '0; bus1.afull_thr_i = 5'd12; bus1.aempty_thr_i = 5'd2;
    test_reset();
    test_basic();
    test_full();
    test_full_rw();
    test_thresholds();
    test_outreg();
    test_flush();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/cc_fifo_ctrl.md
Name: cc_fifo_ctrl

Overview:
- Parametrised successor to the cache controller's basic synchronous FIFO.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count output, a synchronous flush, and sticky overflow/underflow error flags that replace simulation-only checks.
- Adds an optional registered read-data mode.
- Used in the cache controller request/response paths, where producers throttle on almost-full and consumers need exact occupancy.

Parameters:
- FIFO_DEPTH, 16, number of entries; power of two, >= 2.
- DATA_WIDTH, 32, entry width in bits.
- OUTPUT_REG, 0, read mode. 0 = first-word-fall-through (rdata_o shows the head combinationally). 1 = registered (rdata_o valid one cycle after the read is accepted).
- CNT_W, $clog2(FIFO_DEPTH)+1, width of count and threshold signals (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous flush of FIFO contents.
- afull_thr_i  input  CNT_W  almost-full threshold.
- aempty_thr_i  input  CNT_W  almost-empty threshold.
- wren_i  input  1  write request.
- wdata_i  input  DATA_WIDTH  write data.
- full_o  output  1  FIFO full.
- afull_o  output  1  count_o >= afull_thr_i.
- rden_i  input  1  read request.
- rdata_o  output  DATA_WIDTH  read data.
- rvalid_o  output  1  rdata_o valid. OUTPUT_REG=1: one-cycle pulse. OUTPUT_REG=0: equals ~empty_o.
- empty_o  output  1  FIFO empty.
- aempty_o  output  1  count_o <= aempty_thr_i.
- count_o  output  CNT_W  current occupancy, 0..FIFO_DEPTH.
- err_clr_i  input  1  clear sticky error flags.
- ovf_o  output  1  sticky: write attempted while full.
- udf_o  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - wrptr=0, rdptr=0, count_o=0
  - empty_o=1, full_o=0, ovf_o=0, udf_o=0, rvalid_o=0, rdata_o=0
- Reset does not need to clear the storage array.
- Pointers are CNT_W bits wide, with a wrap bit in the MSB:
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Pointers wrap naturally at 2*FIFO_DEPTH.
- Write accepted = wren_i & ~full_o. Read accepted = rden_i & ~empty_o.
  - Both are evaluated against registered flags only.
- Rejected write:
  - No state change; storage is not written.
  - Sets ovf_o on the next edge.
- Rejected read:
  - No pointer change.
  - Sets udf_o on the next edge.
  - OUTPUT_REG=1: rvalid_o stays 0.
- Simultaneous accepted read and write: count_o unchanged; both pointers advance.
- Write when full with a simultaneous read: the write is rejected (ovf_o set); the read is accepted.
- Flags and count:
  - full_o, empty_o and count_o are registered and update on the edge after the operation.
  - A write to an empty FIFO deasserts empty_o after 1 cycle.
- afull_o and aempty_o are combinational compares of registered count_o against the live threshold inputs.
  - Thresholds may change at any time.
  - Out-of-range thresholds are legal (e.g. afull_thr_i > FIFO_DEPTH means afull_o is never asserted).
- Read data, OUTPUT_REG=0:
  - rdata_o = mem[rdptr] combinationally.
  - Undefined-but-stable when empty.
- Read data, OUTPUT_REG=1:
  - On an accepted read, rdata_o <= mem[rdptr] and rvalid_o <= 1.
  - Otherwise rvalid_o <= 0 and rdata_o holds its value.
- flush_i=1:
  - On the edge, wrptr=rdptr=0, count_o=0, empty_o=1, full_o=0, rvalid_o=0.
  - Overrides any write or read in the same cycle: the data is discarded and no error flag is set.
  - ovf_o and udf_o are preserved.
- err_clr_i=1:
  - Clears ovf_o and udf_o on the edge.
  - If a new error occurs in the same cycle, set wins.
- rst has priority over flush_i, which has priority over normal operation.

Test Plan:
1. Reset, then OUTPUT_REG=0, write 0x11, 0x22, 0x33 on consecutive cycles -> count_o = 1, 2, 3; empty_o deasserts 1 cycle after the first write; rdata_o=0x11. Read 3 times -> rdata_o sequence 0x11, 0x22, 0x33; empty_o=1, count_o=0.
2. FIFO_DEPTH=16, write 16 entries -> full_o=1, count_o=16. A 17th write -> ovf_o=1, contents unchanged. Read all -> data in order, no loss.
3. Full FIFO with wren_i and rden_i asserted together -> read accepted, write rejected, count_o=15, ovf_o=1. Then err_clr_i -> ovf_o=0.
4. count_o=5, afull_thr_i=5, aempty_thr_i=4 -> afull_o=1, aempty_o=0. Change afull_thr_i to 6 -> afull_o=0 in the same cycle.
5. OUTPUT_REG=1: write 0xA5 then read -> rvalid_o pulses 1 cycle later with rdata_o=0xA5. Read when empty -> udf_o=1, rvalid_o=0.
6. Hold 8 entries, assert flush_i together with wren_i -> next cycle count_o=0, empty_o=1, error flags unchanged. 20 write/read wrap cycles afterwards -> data intact.
